keccak_round_ctrl: RTL and testbench
====================================

// Module: keccak_round_ctrl
// PURPOSE
//  Sequences one Keccak-f[1600] permutation on the round datapath: loads state,
//  steps the round-constant ROM address, flags first/last round, reports done.
//  Sits between the SHAKE/SHA3 absorb/squeeze logic and the round core + RC ROM.
//  Handles UR rounds per cycle (unrolled core); RC ROM is driven with rc_addr.
// PARAMETERS
//  UR          1   rounds per cycle; must divide NUM_ROUNDS (1,2,3,4,6,8,12,24)
//  NUM_ROUNDS  24  rounds per permutation (<=24, fits 5-bit rc_addr)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  request permutation; accepted only in IDLE
//  hold        in   1  stall: freezes round progress while high (ROUND only)
//  done_ack    in   1  consumer took result; releases DONE
//  abort       in   1  [KECCAK_CTRL_ABORT_EN only] cancel permutation
//  busy        out  1  high in LOAD/ROUND/DONE
//  load_en     out  1  1-cycle strobe: core captures input state
//  round_en    out  1  core applies UR rounds this cycle
//  rc_addr     out  5  RC ROM address of first round this cycle
//  first_round out  1  round_en && rc_addr==0
//  last_round  out  1  round_en && rc_addr==NUM_ROUNDS-UR
//  done        out  1  level: permutation result valid in core
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy=load_en=round_en=done=0; rc_addr=0;
//    first_round=last_round=0. All outputs registered or decoded from state regs.
//  - FSM IDLE -> LOAD -> ROUND -> DONE -> IDLE.
//  - IDLE: start=1 -> LOAD next cycle. start ignored in all other states (no queue).
//  - LOAD: load_en=1 one cycle, rc_addr=0; -> ROUND unconditionally.
//  - ROUND: round_en = !hold. On round_en: if rc_addr==NUM_ROUNDS-UR -> DONE,
//    rc_addr cleared to 0; else rc_addr += UR. hold=1: rc_addr/state frozen,
//    round_en=first_round=last_round=0.
//  - Latency start->done: 1 (LOAD) + NUM_ROUNDS/UR round cycles + stall cycles;
//    done rises the cycle after last_round. UR=1,no hold: start@T0, load_en@T1,
//    round_en T2..T25, done@T26.
//  - DONE: done=1 until done_ack=1; done_ack sampled high -> IDLE next cycle,
//    done=0 that cycle. done_ack outside DONE ignored. start in same cycle as
//    done_ack NOT accepted (IDLE must be seen first).
//  - rc_addr never exceeds NUM_ROUNDS-UR; no wrap within a permutation.
//  - hold in IDLE/LOAD/DONE has no effect.
//  - Reset mid-operation: immediate return to IDLE, done not asserted.
// CONFIGURATION
//  KECCAK_CTRL_ABORT_EN defined: abort port present. abort=1 in LOAD/ROUND/DONE
//    -> IDLE next cycle, rc_addr=0, done never asserted for that permutation;
//    abort has priority over hold and done_ack; ignored in IDLE.
//  Undefined: no abort port; only rst_n cancels a permutation.
// TESTING
//  1 UR=1, start@T0, no hold -> load_en@T1, rc_addr 0..23 on T2..T25,
//    first_round@T2, last_round@T25, done@T26 held until done_ack.
//  2 UR=2 -> rc_addr 0,2,..,22 over 12 cycles, last_round at rc_addr=22, done at +14.
//  3 hold=1 for 3 cycles at rc_addr=5 -> rc_addr stays 5, round_en=0; done 3 cycles late.
//  4 start pulses during ROUND/DONE -> ignored; start+done_ack same cycle -> IDLE,
//    no new LOAD until start re-asserted.
//  5 rst_n low at rc_addr=10 -> all outputs 0 asynchronously, IDLE after release.
//  6 KECCAK_CTRL_ABORT_EN: abort at rc_addr=7 with hold=1 -> IDLE next cycle, done=0;
//    next start runs full 24 rounds from rc_addr=0.

Source files
------------

// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] round sequencer: LOAD, NUM_ROUNDS/UR round cycles, then DONE until acked.
// Latency start->done = 1 + NUM_ROUNDS/UR + hold cycles; hold stalls ROUND only.
// Optional abort port enabled by defining KECCAK_CTRL_ABORT_EN.
module keccak_round_ctrl #(
  parameter int UR         = 1,
  parameter int NUM_ROUNDS = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hold,
  input  logic       done_ack,
`ifdef KECCAK_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       load_en,
  output logic       round_en,
  output logic [4:0] rc_addr,
  output logic       first_round,
  output logic       last_round,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_ADDR = 5'(NUM_ROUNDS - UR);
  localparam logic [4:0] STEP      = 5'(UR);

  state_t state, state_nxt;
  logic   abort_hit;
  logic   at_last;

`ifdef KECCAK_CTRL_ABORT_EN
  assign abort_hit = abort && (state != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign at_last = (rc_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ROUND;
      S_ROUND: if (round_en && at_last) state_nxt = S_DONE;
      S_DONE:  if (done_ack) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort outranks hold and done_ack.
    if (abort_hit) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rc_addr <= '0;
    end else if (abort_hit || state == S_LOAD) begin
      rc_addr <= '0;
    end else if (round_en) begin
      rc_addr <= at_last ? 5'd0 : rc_addr + STEP;
    end
  end

  always_comb begin
    busy        = (state != S_IDLE);
    load_en     = (state == S_LOAD);
    round_en    = (state == S_ROUND) && !hold && !abort_hit;
    first_round = round_en && (rc_addr == 5'd0);
    last_round  = round_en && at_last;
    done        = (state == S_DONE);
  end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Scoreboard bench for keccak_round_ctrl: UR=1 and UR=2 instances, directed permutations.
// Stimulus pushes expected per-cycle outputs; a negedge monitor pops and compares.
// Abort scenario runs only when KECCAK_CTRL_ABORT_EN is defined.
module tb_keccak_round_ctrl;

  typedef struct {
    int          cyc;
    logic [10:0] vec;  // {busy,load_en,round_en,first,last,done,rc_addr}
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start_i    [2];
  logic       hold_i     [2];
  logic       done_ack_i [2];
`ifdef KECCAK_CTRL_ABORT_EN
  logic       abort_i    [2];
`endif
  logic       busy_o     [2];
  logic       load_o     [2];
  logic       round_o    [2];
  logic [4:0] rc_o       [2];
  logic       first_o    [2];
  logic       last_o     [2];
  logic       done_o     [2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  keccak_round_ctrl #(.UR(1), .NUM_ROUNDS(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .hold(hold_i[0]), .done_ack(done_ack_i[0]),
`ifdef KECCAK_CTRL_ABORT_EN
    .abort(abort_i[0]),
`endif
    .busy(busy_o[0]), .load_en(load_o[0]), .round_en(round_o[0]), .rc_addr(rc_o[0]),
    .first_round(first_o[0]), .last_round(last_o[0]), .done(done_o[0])
  );

  keccak_round_ctrl #(.UR(2), .NUM_ROUNDS(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .hold(hold_i[1]), .done_ack(done_ack_i[1]),
`ifdef KECCAK_CTRL_ABORT_EN
    .abort(abort_i[1]),
`endif
    .busy(busy_o[1]), .load_en(load_o[1]), .round_en(round_o[1]), .rc_addr(rc_o[1]),
    .first_round(first_o[1]), .last_round(last_o[1]), .done(done_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [10:0] obs(input int w);
    return {busy_o[w], load_o[w], round_o[w], first_o[w], last_o[w], done_o[w], rc_o[w]};
  endfunction

  // Monitor: any cycle with a pending expectation, or with the DUT busy, is a compared vector.
  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      exp_t e;
      bit   have;
      have = 1'b0;
      if (w == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
      if (w == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
      if (have) begin
        n_vec = n_vec + 1;
        if (obs(w) !== e.vec) begin
          n_err = n_err + 1;
          $display("FAIL dut%0d cyc %0d outputs {busy,load,round,first,last,done,rc}: got %b expected %b",
                   w + 1, cyc, obs(w), e.vec);
        end
      end else if (busy_o[w] !== 1'b0) begin
        n_vec = n_vec + 1;
        n_err = n_err + 1;
        $display("FAIL dut%0d cyc %0d unexpected activity: got %b expected idle", w + 1, cyc, obs(w));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int w, input bit b, input bit l, input bit r, input bit f,
                      input bit la, input bit d, input int rc);
    exp_t e;
    e.cyc = cyc;
    e.vec = {b, l, r, f, la, d, 5'(rc)};
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic direct(input string name, input logic [10:0] got, input logic [10:0] want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // One permutation: start, LOAD, rounds (optional hold at hold_at), DONE for ack_wait+1 cycles.
  // noise drives start high during ROUND/DONE and together with done_ack.
  task automatic perm(input int w, input int ur, input int hold_at, input int hold_len,
                      input int ack_wait, input bit noise);
    int nr;
    nr = 24 / ur;
    start_i[w] = 1'b1;
    tick;
    start_i[w] = 1'b0;
    push(w, 1, 1, 0, 0, 0, 0, 0);
    for (int r = 0; r < nr; r++) begin
      tick;
      if (r * ur == hold_at) begin
        for (int h = 0; h < hold_len; h++) begin
          hold_i[w] = 1'b1;
          push(w, 1, 0, 0, 0, 0, 0, r * ur);
          tick;
        end
      end
      hold_i[w]  = 1'b0;
      start_i[w] = noise;
      push(w, 1, 0, 1, r == 0, r == nr - 1, 0, r * ur);
    end
    for (int k = 0; k < ack_wait; k++) begin
      tick;
      push(w, 1, 0, 0, 0, 0, 1, 0);
    end
    tick;
    done_ack_i[w] = 1'b1;
    start_i[w]    = noise;
    push(w, 1, 0, 0, 0, 0, 1, 0);
    tick;
    done_ack_i[w] = 1'b0;
    start_i[w]    = 1'b0;
    push(w, 0, 0, 0, 0, 0, 0, 0);
    tick;
    push(w, 0, 0, 0, 0, 0, 0, 0);
    tick;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      start_i[w]    = 1'b0;
      hold_i[w]     = 1'b0;
      done_ack_i[w] = 1'b0;
`ifdef KECCAK_CTRL_ABORT_EN
      abort_i[w]    = 1'b0;
`endif
    end
    #2;
    direct("reset_dut1", obs(0), 11'd0);
    direct("reset_dut2", obs(1), 11'd0);
    tick;
    rst_n = 1'b1;
    // done_ack and hold while idle must do nothing
    done_ack_i[0] = 1'b1;
    hold_i[0]     = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    done_ack_i[0] = 1'b0;
    hold_i[0]     = 1'b0;
    tick;

    perm(0, 1, -1, 0, 3, 1'b0);  // UR=1 baseline, done held 3 extra cycles
    perm(1, 2, -1, 0, 0, 1'b0);  // UR=2
    perm(0, 1, 5, 3, 1, 1'b0);   // hold 3 cycles at rc_addr=5
    perm(0, 1, -1, 0, 2, 1'b1);  // start noise in ROUND/DONE and with done_ack
    perm(1, 2, 10, 2, 1, 1'b1);  // UR=2 with hold and noise

    // Asynchronous reset at rc_addr=10
    start_i[0] = 1'b1;
    tick;
    start_i[0] = 1'b0;
    push(0, 1, 1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 10; r++) begin
      tick;
      push(0, 1, 0, 1, r == 0, 0, 0, r);
    end
    tick;
    direct("pre_reset_rc10", obs(0), {6'b101000, 5'd10});
    #1;
    rst_n = 1'b0;
    #1;
    direct("async_reset_outputs", obs(0), 11'd0);
    tick;
    rst_n = 1'b1;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    perm(0, 1, -1, 0, 0, 1'b0);

`ifdef KECCAK_CTRL_ABORT_EN
    // Abort together with hold at rc_addr=7
    start_i[0] = 1'b1;
    tick;
    start_i[0] = 1'b0;
    push(0, 1, 1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 7; r++) begin
      tick;
      push(0, 1, 0, 1, r == 0, 0, 0, r);
    end
    tick;
    hold_i[0]  = 1'b1;
    abort_i[0] = 1'b1;
    push(0, 1, 0, 0, 0, 0, 0, 7);
    tick;
    hold_i[0]  = 1'b0;
    abort_i[0] = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    perm(0, 1, -1, 0, 0, 1'b0);
`endif

    repeat (3) tick;
    direct("scoreboard_drained_dut1", 11'(q0.size()), 11'd0);
    direct("scoreboard_drained_dut2", 11'(q1.size()), 11'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
